age_ordered_rs: RTL and testbench
=================================

Name: age_ordered_rs

Overview:
Parametrised reservation station that succeeds the first-ready/lowest-index station. It holds renamed ALU/AGU/branch-compare ops until both operands are captured, with wakeup from NCDB common-data-bus ports. Dispatch is oldest-ready first through an age matrix, using a valid/ready handshake to the functional unit. It sits between rename/ROB allocate and the ALU; flush comes from the ROB on mispredict.

Parameters:
DEPTH, 8, number of entries (any value >= 2, not restricted to a power of two)
ROB_AW, 3, ROB address (tag) width
XLEN, 32, operand width
NCDB, 2, number of CDB broadcast ports
OPW, 5, ALU opcode width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
i_flush  in  1  synchronous flush; clears all entries
i_issue_valid  in  1  issue request
o_issue_ready  out  1  entry available (registered count < DEPTH)
i_issue_rob_addr  in  ROB_AW  destination ROB tag
i_issue_op  in  OPW  ALU opcode
i_issue_addr_cal  in  1  address-calculation op
i_issue_br_comp  in  1  conditional-branch compare op
i_src1_val, i_src2_val  in  XLEN  operand values when ready
i_src1_rdy, i_src2_rdy  in  1  operand already valid
i_src1_tag, i_src2_tag  in  ROB_AW  producing ROB tag when not ready
i_cdb_valid  in  NCDB  per-port broadcast valid
i_cdb_tag  in  NCDB*ROB_AW  per-port tag; port p occupies bits [p*ROB_AW +: ROB_AW]
i_cdb_data  in  NCDB*XLEN  per-port data
o_disp_valid  out  1  a ready entry is selected
i_disp_ready  in  1  FU accepts this cycle
o_disp_rob_addr  out  ROB_AW  selected entry's ROB tag
o_disp_op  out  OPW  selected entry's opcode
o_disp_addr_cal, o_disp_br_comp  out  1  selected entry's flags
o_disp_src1, o_disp_src2  out  XLEN  selected entry's operands
o_count  out  $clog2(DEPTH+1)  occupied entries
o_empty  out  1  count == 0

Behaviour:
- Reset (async, rstn=0): all entry valid bits 0, age matrix 0, o_count 0, o_issue_ready 1, o_empty 1, o_disp_valid 0, all o_disp_* 0.
- Flush (i_flush=1 at an edge): all entries invalid, count 0. Issue and dispatch in that cycle are discarded. o_disp_valid is forced 0 combinationally while i_flush=1.
- Issue accept: i_issue_valid & o_issue_ready.
  - The op is written to the lowest-index free entry at the edge.
  - Issue while full is ignored; no state change.
  - A slot freed by a same-cycle dispatch is not reused until the next cycle (o_issue_ready comes only from the registered count).
- Issue bypass: for a source with rdy=0, if any CDB port with valid=1 matches its tag in the issue cycle, capture that port's data and set the source ready.
- Wakeup: each cycle, every valid entry's not-ready source compares its tag against all valid CDB ports; a match captures data and sets ready at the edge. Ready sources are never overwritten. If several ports match, the lowest port index wins.
- Entry ready = valid & src1_rdy & src2_rdy, all registered. An entry issued or woken in cycle N is eligible for dispatch no earlier than cycle N+1.
- Age matrix: age[i][j]=1 means entry i is older than entry j.
  - On issue into entry k: set age[j][k]=1 for every currently valid j, and clear row k.
  - On free: clear row and column.
- Select: o_disp_valid=1 when some entry is ready. The chosen entry is the ready i with no ready j where age[j][i]=1. o_disp_* are combinational from that entry and are 0 when o_disp_valid=0.
- Handshake: dispatch fires on o_disp_valid & i_disp_ready; the entry is freed at that edge. While i_disp_ready=0, the selection may change if an older entry becomes ready (no hold requirement).
- Count: next = count + issue_fire - disp_fire. It never exceeds DEPTH and never underflows.
- Invariant: the entry valid bits and o_count always agree.

Decomposition:
- Package rs_pkg holds:
  - rs_entry_t struct: valid, rob_addr, op, addr_cal, br_comp, src1/src2 {rdy, tag, val}.
  - A localparam-function CNT_W(DEPTH).
  - Default parameter constants.
- Sub-module rs_age_matrix(DEPTH):
  - inputs: alloc one-hot, free one-hot, ready vector, valid vector.
  - output: oldest-ready one-hot.
  - The top handles storage, wakeup, and the handshake.

Test Plan:
- Issue 3 ready ops (tags 1,2,3) with i_disp_ready=1 -> dispatch order 1,2,3 on consecutive cycles; o_count 0 at end.
- Issue tag 4 waiting src1 tag 5, then tag 6 fully ready; broadcast port1 tag5 data 0x1E -> 6 dispatches first, then 4 with o_disp_src1=0x1E one cycle after broadcast.
- Fill all 8 entries with unready ops, then assert issue -> o_issue_ready=0 and the 9th op is dropped. Broadcast frees one, dispatch -> o_issue_ready=1 the next cycle.
- Issue an op waiting tags 5/6 in the same cycle as port0 tag5=30 and port1 tag6=15 -> entry ready next cycle, dispatched src1=30, src2=15.
- Entries in free slots 0 and 2 made ready with slot 2 older (issued first after wrap) -> slot 2 is dispatched first despite the higher index.
- 4 valid entries, i_disp_ready=0, assert i_flush -> o_disp_valid=0 that cycle, o_count=0 and o_empty=1 the next; async rstn pulse mid-fill -> all outputs at reset values immediately.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared defaults, counter sizing and the entry layout for the age-ordered reservation station.
package rs_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ROB_AW = 3;
    localparam int DEF_XLEN   = 32;
    localparam int DEF_NCDB   = 2;
    localparam int DEF_OPW    = 5;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int CNT_W(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Entry layout at the default widths; the top re-declares it at its own parameter widths.
    typedef struct packed {
        logic                  rdy;
        logic [DEF_ROB_AW-1:0] tag;
        logic [DEF_XLEN-1:0]   val;
    } rs_src_t;

    typedef struct packed {
        logic                  valid;
        logic [DEF_ROB_AW-1:0] rob_addr;
        logic [DEF_OPW-1:0]    op;
        logic                  addr_cal;
        logic                  br_comp;
        rs_src_t               src1;
        rs_src_t               src2;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// Relative-age tracker: picks the oldest ready entry as a one-hot vector.
module rs_age_matrix
    import rs_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] ready,
    input  logic [DEPTH-1:0] valid,
    output logic [DEPTH-1:0] oldest
);

    // age[i][j] = 1 means entry i is older than entry j
    logic [DEPTH-1:0] age [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (flush || free[i] || free[j] || alloc[i])
                        age[i][j] <= 1'b0;
                    else if (alloc[j])
                        age[i][j] <= valid[i];
                end
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            logic [DEPTH-1:0] older;
            for (gj = 0; gj < DEPTH; gj++) begin : g_col
                assign older[gj] = age[gj][gi];
            end
            assign oldest[gi] = ready[gi] & ~|(older & ready);
        end
    endgenerate

endmodule

// File: rtl/age_ordered_rs.sv
// Reservation station: captures operands from issue and CDB wakeup, then dispatches
// the oldest ready entry to the functional unit over a valid/ready handshake.
module age_ordered_rs
    import rs_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ROB_AW = DEF_ROB_AW,
    parameter int XLEN   = DEF_XLEN,
    parameter int NCDB   = DEF_NCDB,
    parameter int OPW    = DEF_OPW
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_flush,
    input  logic                     i_issue_valid,
    output logic                     o_issue_ready,
    input  logic [ROB_AW-1:0]        i_issue_rob_addr,
    input  logic [OPW-1:0]           i_issue_op,
    input  logic                     i_issue_addr_cal,
    input  logic                     i_issue_br_comp,
    input  logic [XLEN-1:0]          i_src1_val,
    input  logic [XLEN-1:0]          i_src2_val,
    input  logic                     i_src1_rdy,
    input  logic                     i_src2_rdy,
    input  logic [ROB_AW-1:0]        i_src1_tag,
    input  logic [ROB_AW-1:0]        i_src2_tag,
    input  logic [NCDB-1:0]          i_cdb_valid,
    input  logic [NCDB*ROB_AW-1:0]   i_cdb_tag,
    input  logic [NCDB*XLEN-1:0]     i_cdb_data,
    output logic                     o_disp_valid,
    input  logic                     i_disp_ready,
    output logic [ROB_AW-1:0]        o_disp_rob_addr,
    output logic [OPW-1:0]           o_disp_op,
    output logic                     o_disp_addr_cal,
    output logic                     o_disp_br_comp,
    output logic [XLEN-1:0]          o_disp_src1,
    output logic [XLEN-1:0]          o_disp_src2,
    output logic [CNT_W(DEPTH)-1:0]  o_count,
    output logic                     o_empty
);

    localparam int CW = CNT_W(DEPTH);

    typedef struct packed {
        logic              rdy;
        logic [ROB_AW-1:0] tag;
        logic [XLEN-1:0]   val;
    } src_t;

    typedef struct packed {
        logic              valid;
        logic [ROB_AW-1:0] rob_addr;
        logic [OPW-1:0]    op;
        logic              addr_cal;
        logic              br_comp;
        src_t              src1;
        src_t              src2;
    } entry_t;

    entry_t           entries [DEPTH];
    logic [CW-1:0]    count_reg;
    logic [DEPTH-1:0] valid_vec, ready_vec, alloc, free, oldest, sel;
    logic             issue_fire, disp_fire;
    entry_t           issue_entry, disp_entry;

    // Snoop all CDB ports; scanning downward lets the lowest matching port win.
    function automatic src_t capture(input src_t s);
        src_t r;
        r = s;
        for (int p = NCDB - 1; p >= 0; p--) begin
            if (!s.rdy && i_cdb_valid[p] && i_cdb_tag[p*ROB_AW +: ROB_AW] == s.tag) begin
                r.rdy = 1'b1;
                r.val = i_cdb_data[p*XLEN +: XLEN];
            end
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_vec
            assign valid_vec[gi] = entries[gi].valid;
            assign ready_vec[gi] = entries[gi].valid & entries[gi].src1.rdy & entries[gi].src2.rdy;
        end
    endgenerate

    assign o_issue_ready = (count_reg != CW'(DEPTH));
    assign issue_fire    = i_issue_valid & o_issue_ready & ~i_flush;
    assign sel           = i_flush ? '0 : oldest;
    assign o_disp_valid  = |sel;
    assign disp_fire     = o_disp_valid & i_disp_ready;
    assign free          = sel & {DEPTH{disp_fire}};

    always_comb begin
        logic found;
        alloc = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!entries[i].valid && !found) begin
                alloc[i] = issue_fire;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        issue_entry          = '0;
        issue_entry.valid    = 1'b1;
        issue_entry.rob_addr = i_issue_rob_addr;
        issue_entry.op       = i_issue_op;
        issue_entry.addr_cal = i_issue_addr_cal;
        issue_entry.br_comp  = i_issue_br_comp;
        issue_entry.src1     = capture({i_src1_rdy, i_src1_tag, i_src1_val});
        issue_entry.src2     = capture({i_src2_rdy, i_src2_tag, i_src2_val});
    end

    // sel is one-hot or zero, so an OR-style mux yields all zeros when nothing is selected
    always_comb begin
        disp_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) disp_entry = entries[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            count_reg <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
            count_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (free[i]) begin
                    entries[i].valid <= 1'b0;
                end else if (alloc[i]) begin
                    entries[i] <= issue_entry;
                end else if (entries[i].valid) begin
                    entries[i].src1 <= capture(entries[i].src1);
                    entries[i].src2 <= capture(entries[i].src2);
                end
            end
            count_reg <= count_reg + CW'(issue_fire) - CW'(disp_fire);
        end
    end

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk    (clk),
        .rstn   (rstn),
        .flush  (i_flush),
        .alloc  (alloc),
        .free   (free),
        .ready  (ready_vec),
        .valid  (valid_vec),
        .oldest (oldest)
    );

    assign o_disp_rob_addr = disp_entry.rob_addr;
    assign o_disp_op       = disp_entry.op;
    assign o_disp_addr_cal = disp_entry.addr_cal;
    assign o_disp_br_comp  = disp_entry.br_comp;
    assign o_disp_src1     = disp_entry.src1.val;
    assign o_disp_src2     = disp_entry.src2.val;
    assign o_count         = count_reg;
    assign o_empty         = (count_reg == '0);

endmodule

// File: tb/tb_age_ordered_rs.sv
// Bench for age_ordered_rs: directed scenarios plus random traffic, checked against an
// issue-ordered queue model where the oldest ready op is simply the first ready one in the queue.
module tb_age_ordered_rs;
    import rs_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ROB_AW = 3;
    localparam int XLEN   = 32;
    localparam int NCDB   = 2;
    localparam int OPW    = 5;
    localparam int CW     = CNT_W(DEPTH);

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   i_flush, i_issue_valid, o_issue_ready;
    logic [ROB_AW-1:0]      i_issue_rob_addr;
    logic [OPW-1:0]         i_issue_op;
    logic                   i_issue_addr_cal, i_issue_br_comp;
    logic [XLEN-1:0]        i_src1_val, i_src2_val;
    logic                   i_src1_rdy, i_src2_rdy;
    logic [ROB_AW-1:0]      i_src1_tag, i_src2_tag;
    logic [NCDB-1:0]        i_cdb_valid;
    logic [NCDB*ROB_AW-1:0] i_cdb_tag;
    logic [NCDB*XLEN-1:0]   i_cdb_data;
    logic                   o_disp_valid, i_disp_ready;
    logic [ROB_AW-1:0]      o_disp_rob_addr;
    logic [OPW-1:0]         o_disp_op;
    logic                   o_disp_addr_cal, o_disp_br_comp;
    logic [XLEN-1:0]        o_disp_src1, o_disp_src2;
    logic [CW-1:0]          o_count;
    logic                   o_empty;

    always #5 clk = ~clk;

    age_ordered_rs #(.DEPTH(DEPTH), .ROB_AW(ROB_AW), .XLEN(XLEN), .NCDB(NCDB), .OPW(OPW)) dut (
        .clk(clk), .rstn(rstn), .i_flush(i_flush),
        .i_issue_valid(i_issue_valid), .o_issue_ready(o_issue_ready),
        .i_issue_rob_addr(i_issue_rob_addr), .i_issue_op(i_issue_op),
        .i_issue_addr_cal(i_issue_addr_cal), .i_issue_br_comp(i_issue_br_comp),
        .i_src1_val(i_src1_val), .i_src2_val(i_src2_val),
        .i_src1_rdy(i_src1_rdy), .i_src2_rdy(i_src2_rdy),
        .i_src1_tag(i_src1_tag), .i_src2_tag(i_src2_tag),
        .i_cdb_valid(i_cdb_valid), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
        .o_disp_valid(o_disp_valid), .i_disp_ready(i_disp_ready),
        .o_disp_rob_addr(o_disp_rob_addr), .o_disp_op(o_disp_op),
        .o_disp_addr_cal(o_disp_addr_cal), .o_disp_br_comp(o_disp_br_comp),
        .o_disp_src1(o_disp_src1), .o_disp_src2(o_disp_src2),
        .o_count(o_count), .o_empty(o_empty)
    );

    typedef struct packed {
        logic              rdy;
        logic [ROB_AW-1:0] tag;
        logic [XLEN-1:0]   val;
    } msrc_t;

    typedef struct {
        logic [ROB_AW-1:0] rob;
        logic [OPW-1:0]    op;
        logic              ac;
        logic              bc;
        msrc_t             s1;
        msrc_t             s2;
    } mop_t;

    mop_t q[$];   // resident ops, oldest first
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // First valid port carrying the awaited tag supplies the value.
    function automatic msrc_t snoop(input msrc_t s);
        for (int p = 0; p < NCDB; p++) begin
            if (!s.rdy && i_cdb_valid[p] && i_cdb_tag[p*ROB_AW +: ROB_AW] == s.tag) begin
                s.rdy = 1'b1;
                s.val = i_cdb_data[p*XLEN +: XLEN];
            end
        end
        return s;
    endfunction

    task automatic idle();
        i_flush       = 1'b0;
        i_issue_valid = 1'b0;
        i_cdb_valid   = '0;
    endtask

    task automatic issue(input logic [ROB_AW-1:0] rob,
                         input logic r1, input logic [ROB_AW-1:0] t1, input logic [XLEN-1:0] v1,
                         input logic r2, input logic [ROB_AW-1:0] t2, input logic [XLEN-1:0] v2);
        i_issue_valid    = 1'b1;
        i_issue_rob_addr = rob;
        i_issue_op       = OPW'($urandom);
        i_issue_addr_cal = 1'($urandom);
        i_issue_br_comp  = 1'($urandom);
        i_src1_rdy = r1; i_src1_tag = t1; i_src1_val = v1;
        i_src2_rdy = r2; i_src2_tag = t2; i_src2_val = v2;
    endtask

    task automatic bcast(input int p, input logic [ROB_AW-1:0] tag, input logic [XLEN-1:0] data);
        i_cdb_valid[p]                = 1'b1;
        i_cdb_tag[p*ROB_AW +: ROB_AW] = tag;
        i_cdb_data[p*XLEN +: XLEN]    = data;
    endtask

    // Called at posedge+1 with inputs applied: check outputs mid-cycle, then advance model at the edge.
    task automatic cycle();
        int   sel;
        mop_t e;
        bit   full;
        #3;
        sel = -1;
        if (!i_flush)
            foreach (q[i]) if (sel < 0 && q[i].s1.rdy && q[i].s2.rdy) sel = i;
        if (sel >= 0) e = q[sel];
        else e = '{default: '0};
        check("count",       64'(o_count),         64'(q.size()));
        check("empty",       64'(o_empty),         64'(q.size() == 0));
        check("issue_ready", 64'(o_issue_ready),   64'(q.size() < DEPTH));
        check("disp_valid",  64'(o_disp_valid),    64'(sel >= 0));
        check("disp_rob",    64'(o_disp_rob_addr), 64'(e.rob));
        check("disp_op",     64'(o_disp_op),       64'(e.op));
        check("disp_flags",  64'({o_disp_addr_cal, o_disp_br_comp}), 64'({e.ac, e.bc}));
        check("disp_src1",   64'(o_disp_src1),     64'(e.s1.val));
        check("disp_src2",   64'(o_disp_src2),     64'(e.s2.val));
        @(posedge clk);
        if (i_flush) begin
            q.delete();
        end else begin
            full = (q.size() >= DEPTH);
            if (sel >= 0 && i_disp_ready) begin
                $display("disp rob=%0d op=%0d src1=%h src2=%h", e.rob, e.op, e.s1.val, e.s2.val);
                q.delete(sel);
            end
            foreach (q[i]) begin
                q[i].s1 = snoop(q[i].s1);
                q[i].s2 = snoop(q[i].s2);
            end
            if (i_issue_valid && !full) begin
                e.rob = i_issue_rob_addr;
                e.op  = i_issue_op;
                e.ac  = i_issue_addr_cal;
                e.bc  = i_issue_br_comp;
                e.s1  = snoop({i_src1_rdy, i_src1_tag, i_src1_val});
                e.s2  = snoop({i_src2_rdy, i_src2_tag, i_src2_val});
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 64'(o_count), 64'd0);
        check({tag, "_empty"}, 64'(o_empty), 64'd1);
        check({tag, "_ready"}, 64'(o_issue_ready), 64'd1);
        check({tag, "_dvalid"}, 64'(o_disp_valid), 64'd0);
        check({tag, "_dfields"}, 64'({o_disp_rob_addr, o_disp_op, o_disp_addr_cal, o_disp_br_comp}), 64'd0);
        check({tag, "_dsrc"}, {o_disp_src1, o_disp_src2}, 64'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2 rstn = 1'b0;
        #1 check_reset_outputs("async_rst");
        q.delete();
        idle();
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        i_disp_ready = 1'b0;
        i_cdb_tag = '0; i_cdb_data = '0;
        issue(3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
        idle();
        #3 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk);
        #1;

        // three ready ops dispatched in issue order
        i_disp_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            idle(); issue(3'(k), 1'b1, 3'd0, 32'(k * 16), 1'b1, 3'd0, 32'(k + 100)); cycle();
        end
        idle(); repeat (3) cycle();

        // waiting op overtaken by a younger ready op, then woken by port 1
        idle(); issue(3'd4, 1'b0, 3'd5, 32'd0, 1'b1, 3'd0, 32'h44); cycle();
        idle(); issue(3'd6, 1'b1, 3'd0, 32'h66, 1'b1, 3'd0, 32'h67); cycle();
        idle(); cycle();
        idle(); bcast(1, 3'd5, 32'h1E); cycle();
        idle(); repeat (2) cycle();

        // fill with unready ops, drop the ninth, wake all, dispatch one, slot reopens
        i_disp_ready = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) begin
            idle(); issue(3'(k), 1'b0, 3'd7, 32'd0, 1'b1, 3'd0, 32'(k)); cycle();
        end
        idle(); bcast(0, 3'd7, 32'hAB); cycle();
        idle(); i_disp_ready = 1'b1; cycle();
        idle(); i_disp_ready = 1'b0; cycle();
        idle(); i_disp_ready = 1'b1; repeat (DEPTH + 1) cycle();

        // issue-cycle bypass from both ports
        idle(); issue(3'd2, 1'b0, 3'd5, 32'd0, 1'b0, 3'd6, 32'd0);
        bcast(0, 3'd5, 32'd30); bcast(1, 3'd6, 32'd15); cycle();
        idle(); repeat (2) cycle();

        // slot 2 becomes older than slot 0 after slot reuse
        i_disp_ready = 1'b0;
        idle(); issue(3'd1, 1'b0, 3'd4, 32'd0, 1'b1, 3'd0, 32'h1); cycle();
        idle(); issue(3'd2, 1'b0, 3'd3, 32'd0, 1'b1, 3'd0, 32'h2); cycle();
        idle(); issue(3'd3, 1'b1, 3'd0, 32'h3, 1'b1, 3'd0, 32'h3); cycle();
        idle(); i_disp_ready = 1'b1; cycle();
        idle(); i_disp_ready = 1'b0; issue(3'd5, 1'b0, 3'd5, 32'd0, 1'b1, 3'd0, 32'h5); cycle();
        idle(); bcast(0, 3'd4, 32'h40); cycle();
        idle(); i_disp_ready = 1'b1; cycle();
        idle(); i_disp_ready = 1'b0; issue(3'd6, 1'b0, 3'd6, 32'd0, 1'b1, 3'd0, 32'h6); cycle();
        idle(); bcast(0, 3'd5, 32'h50); bcast(1, 3'd6, 32'h60); cycle();
        idle(); i_disp_ready = 1'b1; repeat (2) cycle();
        idle(); bcast(0, 3'd3, 32'h30); cycle();
        idle(); repeat (2) cycle();

        // flush with four resident ops, then reset pulse mid-fill
        i_disp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idle(); issue(3'(k), 1'b1, 3'd0, 32'(k), 1'b1, 3'd0, 32'(k)); cycle();
        end
        idle(); i_flush = 1'b1; issue(3'd7, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0, 32'd7); cycle();
        idle(); cycle();
        for (int k = 0; k < 2; k++) begin
            idle(); issue(3'(k), 1'b1, 3'd0, 32'(k), 1'b0, 3'd2, 32'd0); cycle();
        end
        async_reset();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            idle();
            if ($urandom_range(99) < 60)
                issue(ROB_AW'($urandom), $urandom_range(99) < 50, ROB_AW'($urandom), XLEN'($urandom),
                      $urandom_range(99) < 50, ROB_AW'($urandom), XLEN'($urandom));
            for (int p = 0; p < NCDB; p++)
                if ($urandom_range(99) < 40) bcast(p, ROB_AW'($urandom), XLEN'($urandom));
            i_disp_ready = $urandom_range(99) < 70;
            i_flush      = $urandom_range(99) < 2;
            if (n == 750) async_reset();
            else cycle();
        end

        idle(); i_flush = 1'b1; cycle();
        idle(); cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
